// File: rtl/run_seq.sv
// Run sequencer: handshakes a run request, holds the core in reset RST_CYC cycles, runs it under a watchdog, then freezes it.
// Acknowledge after RST_CYC+n edges for an n-cycle run; done holds until req drops, and a new run needs req low then high.
module run_seq #(
   parameter int unsigned RST_CYC = 2,
   parameter int unsigned CW      = 16,
   parameter int unsigned MAX_CYC = 16'hFFFF
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          req,
   input  logic          core_done,
   output logic          core_reset,
   output logic          core_en,
   output logic          done,
   output logic          busy,
   output logic          timeout,
   output logic [CW-1:0] cycles
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RST  = 2'd1,
      S_RUN  = 2'd2,
      S_DONE = 2'd3
   } state_t;

   localparam logic [3:0]    RST_LOAD = 4'(RST_CYC - 1);
   localparam logic [CW-1:0] MAX_LIM  = CW'(MAX_CYC);
   localparam logic [CW-1:0] CYC_ONE  = {{(CW-1){1'b0}}, 1'b1};

   state_t        state_q;
   state_t        state_d;
   logic [3:0]    rst_cnt_q;
   logic [CW-1:0] cycles_q;
   logic          timeout_q;
   logic [CW-1:0] cyc_inc;
   logic          wdog_hit;

   assign cyc_inc  = cycles_q + CYC_ONE;
   assign wdog_hit = (cyc_inc == MAX_LIM);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE: if (req)               state_d = S_RST;
         S_RST:  if (rst_cnt_q == 4'd0) state_d = S_RUN;
         S_RUN:  if (core_done || wdog_hit) state_d = S_DONE;
         S_DONE: if (!req)              state_d = S_IDLE;
         default:                       state_d = S_IDLE;
      endcase
   end

   // Completion takes priority over the watchdog when both land on the same edge.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rst_cnt_q <= 4'd0;
         cycles_q  <= '0;
         timeout_q <= 1'b0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (req) begin
                  rst_cnt_q <= RST_LOAD;
                  cycles_q  <= '0;
                  timeout_q <= 1'b0;
               end
            end
            S_RST: begin
               if (rst_cnt_q != 4'd0) rst_cnt_q <= rst_cnt_q - 4'd1;
            end
            S_RUN: begin
               cycles_q <= cyc_inc;
               if (!core_done && wdog_hit) timeout_q <= 1'b1;
            end
            default: ;
         endcase
      end
   end

   always_comb begin
      core_reset = 1'b1;
      core_en    = 1'b0;
      done       = 1'b0;
      busy       = 1'b0;
      case (state_q)
         S_IDLE: core_reset = 1'b1;
         S_RST:  busy       = 1'b1;
         S_RUN: begin
            core_reset = 1'b0;
            core_en    = 1'b1;
            busy       = 1'b1;
         end
         S_DONE: begin
            core_reset = 1'b0;
            done       = 1'b1;
         end
         default: ;
      endcase
   end

   assign cycles  = cycles_q;
   assign timeout = timeout_q;

endmodule
